// File: rtl/rotate_seq_ctrl_pkg.sv
// Shared state and downstream-select encodings for the rotate sequence controller.
package rotate_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

endpackage

// File: rtl/rotate_seq_ctrl.sv
// Sequences load + N rotate commands into a downstream rotate register.
// Optional macro ROTSEQ_PAUSE_EN adds a pause input that stalls the rotate phase.
module rotate_seq_ctrl
    import rotate_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [WIDTH-1:0] pattern,
`ifdef ROTSEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pattern_q, pattern_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hold;

`ifdef ROTSEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pattern_d = pattern;
                    dir_d     = dir;
                    cnt_d     = steps;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = (cnt_q != '0) ? ROTATE : DONE;
            end
            ROTATE: begin
                // Counter reaches zero on the last rotate cycle, so the full range never wraps.
                if (!hold) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        sel  = SEL_HOLD;
        data = '0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE: ;
            LOAD: begin
                sel  = SEL_LOAD;
                data = pattern_q;
                busy = 1'b1;
            end
            ROTATE: begin
                sel  = hold ? SEL_HOLD : (dir_q ? SEL_RIGHT : SEL_LEFT);
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
        endcase
    end

endmodule
